mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter_arb_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned WDATA_W_DEF = 8;
  localparam int unsigned RDATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Two-requester winner selection; i_last names the requester served most recently.
module arb_pick (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req0 && i_req1) begin
      // On contention the requester not served last wins.
      o_gnt = i_last ? 2'b01 : 2'b10;
    end else if (i_req0) begin
      o_gnt = 2'b01;
    end else if (i_req1) begin
      o_gnt = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master single-port RAM arbiter: IDLE -> ACCESS -> DONE per transfer.
// Define ARB_RR_EN for round-robin contention; default build is fixed priority (m0 wins).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned WDATA_W = WDATA_W_DEF,
  parameter int unsigned RDATA_W = RDATA_W_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [ADDR_W-1:0]  m0_adrs,
  input  logic [WDATA_W-1:0] m0_wdata,
  output logic               m0_gnt,
  output logic               m0_ack,
  output logic [RDATA_W-1:0] m0_rdata,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [ADDR_W-1:0]  m1_adrs,
  input  logic [WDATA_W-1:0] m1_wdata,
  output logic               m1_gnt,
  output logic               m1_ack,
  output logic [RDATA_W-1:0] m1_rdata,
  output logic               ram_rw,
  output logic [ADDR_W-1:0]  ram_adrs,
  output logic [WDATA_W-1:0] ram_din,
  input  logic [RDATA_W-1:0] ram_dout
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_owner;
  logic                 w_owner_nxt;
  logic [1:0]           w_pick;
  logic                 w_last;
  logic                 w_any_req;
  logic                 w_sel_we;
  logic [ADDR_W-1:0]    w_sel_adrs;
  logic [WDATA_W-1:0]   w_sel_wdata;
  logic [RDATA_W-1:0]   r_rdata0;
  logic [RDATA_W-1:0]   r_rdata1;

  assign w_any_req = m0_req | m1_req;

`ifdef ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_last <= 1'b1;
    end else if (r_state == IDLE && w_any_req) begin
      r_last <= w_pick[1];
    end
  end

  assign w_last = r_last;
`else
  // Tying last-served to m1 makes the picker always favour m0.
  assign w_last = 1'b1;
`endif

  arb_pick u_arb_pick (
    .i_req0 (m0_req),
    .i_req1 (m1_req),
    .i_last (w_last),
    .o_gnt  (w_pick)
  );

  assign w_sel_we    = r_owner ? m1_we    : m0_we;
  assign w_sel_adrs  = r_owner ? m1_adrs  : m0_adrs;
  assign w_sel_wdata = r_owner ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    ram_rw      = 1'b0;
    ram_adrs    = '0;
    ram_din     = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ACCESS;
          w_owner_nxt = w_pick[1];
        end
      end
      ACCESS: begin
        w_state_nxt = DONE;
        m0_gnt      = ~r_owner;
        m1_gnt      = r_owner;
        // clr gates the write strobe so an aborted access never reaches the RAM.
        ram_rw      = w_sel_we & ~clr;
        ram_adrs    = w_sel_adrs;
        ram_din     = w_sel_wdata;
      end
      DONE: begin
        w_state_nxt = IDLE;
        m0_gnt      = ~r_owner;
        m1_gnt      = r_owner;
        m0_ack      = ~r_owner;
        m1_ack      = r_owner;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == ACCESS && !w_sel_we) begin
      if (r_owner) begin
        r_rdata1 <= ram_dout;
      end else begin
        r_rdata0 <= ram_dout;
      end
    end
  end

  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;

endmodule
